// File: rtl/cv32e40n_apu_arb_pkg.sv
// Types and sizing helpers for the shared-APU arbiter.
package cv32e40n_apu_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned NUM_REQ_DFLT         = 2;
  localparam int unsigned MAX_OUTSTANDING_DFLT = 4;
  localparam int unsigned REQ_IDX_W            = $clog2(NUM_REQ_DFLT);

  // Requester-index width for an arbitrary requester count (never zero).
  function automatic int unsigned req_idx_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_core_pkg.sv
// APU interface widths shared by the cores, the arbiter and the APU instances.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_NARGS_CPU    = 3;
  localparam int unsigned APU_WOP_CPU      = 6;
  localparam int unsigned APU_NDSFLAGS_CPU = 15;
  localparam int unsigned APU_NUSFLAGS_CPU = 5;

endpackage

// File: rtl/cv32e40n_apu_id_fifo.sv
// In-order queue of requester IDs, one entry per accepted but unanswered APU transaction.
module cv32e40n_apu_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic [W-1:0] data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40n_apu_arbiter.sv
// Shares one APU between NUM_REQ requesters: round-robin request arbitration with
// grant lock, and an ID queue that routes in-order responses back to their issuer.
module cv32e40n_apu_arbiter
  import cv32e40p_apu_core_pkg::*;
  import cv32e40n_apu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = NUM_REQ_DFLT,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DFLT
) (
  input  logic                                              clk_i,
  input  logic                                              rst_ni,
  input  logic [NUM_REQ-1:0]                                req_req_i,
  input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]       req_operands_i,
  input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]               req_op_i,
  input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]          req_flags_i,
  output logic [NUM_REQ-1:0]                                req_gnt_o,
  output logic [NUM_REQ-1:0]                                req_rvalid_o,
  output logic [31:0]                                       req_result_o,
  output logic [APU_NUSFLAGS_CPU-1:0]                       req_flags_o,
  output logic                                              apu_req_o,
  output logic [APU_NARGS_CPU-1:0][31:0]                    apu_operands_o,
  output logic [APU_WOP_CPU-1:0]                            apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0]                       apu_flags_o,
  input  logic                                              apu_gnt_i,
  input  logic                                              apu_rvalid_i,
  input  logic [31:0]                                       apu_result_i,
  input  logic [APU_NUSFLAGS_CPU-1:0]                       apu_flags_i,
  output logic                                              busy_o,
  output logic                                              err_spurious_o
);

  localparam int unsigned IDX_W = req_idx_w(NUM_REQ);

  arb_state_e       state_q;
  logic [IDX_W-1:0] lock_sel_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             err_q;
  logic [IDX_W-1:0] arb_sel;
  logic             arb_hit;
  int unsigned      rr_idx;
  logic [IDX_W-1:0] sel;
  logic             cand_valid;
  logic             accept;
  logic             resp;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head;

  // First active requester at or after the round-robin pointer.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = rr_ptr_q;
    rr_idx  = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      rr_idx = (32'(rr_ptr_q) + off) % NUM_REQ;
      if (!arb_hit && req_req_i[IDX_W'(rr_idx)]) begin
        arb_hit = 1'b1;
        arb_sel = IDX_W'(rr_idx);
      end
    end
  end

  // A stalled request keeps its owner until granted or withdrawn.
  always_comb begin
    sel        = arb_sel;
    cand_valid = arb_hit;
    if (state_q == ARB_LOCKED) begin
      sel        = lock_sel_q;
      cand_valid = req_req_i[lock_sel_q];
    end
  end

  assign apu_req_o = cand_valid & ~fifo_full & rst_ni;
  assign accept    = apu_req_o & apu_gnt_i;
  assign resp      = apu_rvalid_i & ~fifo_empty & rst_ni;

  always_comb begin
    req_gnt_o      = '0;
    req_rvalid_o   = '0;
    apu_operands_o = '0;
    apu_op_o       = '0;
    apu_flags_o    = '0;
    if (accept) req_gnt_o[sel] = 1'b1;
    if (resp) req_rvalid_o[head] = 1'b1;
    if (apu_req_o) begin
      apu_operands_o = req_operands_i[sel];
      apu_op_o       = req_op_i[sel];
      apu_flags_o    = req_flags_i[sel];
    end
  end

  assign req_result_o   = rst_ni ? apu_result_i : '0;
  assign req_flags_o    = rst_ni ? apu_flags_i : '0;
  assign busy_o         = ~fifo_empty;
  assign err_spurious_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      lock_sel_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      if (apu_rvalid_i && fifo_empty) err_q <= 1'b1;
      if (accept) rr_ptr_q <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
      case (state_q)
        ARB_IDLE: begin
          if (apu_req_o && !apu_gnt_i) begin
            state_q    <= ARB_LOCKED;
            lock_sel_q <= sel;
          end
        end
        ARB_LOCKED: begin
          if (!req_req_i[lock_sel_q] || apu_gnt_i) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  cv32e40n_apu_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (IDX_W)
  ) u_id_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (accept),
    .data   (sel),
    .pop    (resp),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head)
  );

endmodule

// File: tb/tb_cv32e40n_apu_arbiter.sv
// Bench for the shared-APU arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based transaction model.
module tb_cv32e40n_apu_arbiter;
  import cv32e40p_apu_core_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned MO = 4;

  logic clk = 1'b0;
  logic rst_ni;
  logic [NR-1:0]                          req_req;
  logic [NR-1:0][APU_NARGS_CPU-1:0][31:0] req_ops;
  logic [NR-1:0][APU_WOP_CPU-1:0]         req_op;
  logic [NR-1:0][APU_NDSFLAGS_CPU-1:0]    req_fl;
  logic [NR-1:0]                          req_gnt;
  logic [NR-1:0]                          req_rvalid;
  logic [31:0]                            req_result;
  logic [APU_NUSFLAGS_CPU-1:0]            req_rflags;
  logic                                   apu_req;
  logic [APU_NARGS_CPU-1:0][31:0]         apu_ops;
  logic [APU_WOP_CPU-1:0]                 apu_op;
  logic [APU_NDSFLAGS_CPU-1:0]            apu_fl;
  logic                                   apu_gnt;
  logic                                   apu_rvalid;
  logic [31:0]                            apu_result;
  logic [APU_NUSFLAGS_CPU-1:0]            apu_rflags;
  logic                                   busy;
  logic                                   err;

  cv32e40n_apu_arbiter #(.NUM_REQ(NR), .MAX_OUTSTANDING(MO)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .req_req_i      (req_req),
    .req_operands_i (req_ops),
    .req_op_i       (req_op),
    .req_flags_i    (req_fl),
    .req_gnt_o      (req_gnt),
    .req_rvalid_o   (req_rvalid),
    .req_result_o   (req_result),
    .req_flags_o    (req_rflags),
    .apu_req_o      (apu_req),
    .apu_operands_o (apu_ops),
    .apu_op_o       (apu_op),
    .apu_flags_o    (apu_fl),
    .apu_gnt_i      (apu_gnt),
    .apu_rvalid_i   (apu_rvalid),
    .apu_result_i   (apu_result),
    .apu_flags_i    (apu_rflags),
    .busy_o         (busy),
    .err_spurious_o (err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Transaction-level model: FIFO of issuer IDs, next-priority requester, held requester.
  int q[$];
  int rr;
  int held;
  bit err_m;

  int                             cand;
  bit                             e_acc;
  bit                             e_resp;
  logic [NR-1:0]                  e_gnt;
  logic [NR-1:0]                  e_rv;
  logic [APU_NARGS_CPU-1:0][31:0] e_ops;
  logic [APU_WOP_CPU-1:0]         e_op;
  logic [APU_NDSFLAGS_CPU-1:0]    e_fl;

  typedef struct {
    logic [NR-1:0] req;
    logic          gnt;
    logic          rv;
    logic [NR-1:0] x_gnt;
    logic [NR-1:0] x_rv;
    logic          x_apu;
    logic          x_busy;
    logic          rst_before;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rr    = 0;
    held  = -1;
    err_m = 1'b0;
  endtask

  task automatic model_eval();
    int j;
    cand = -1;
    if (q.size() < MO) begin
      if (held >= 0) begin
        if (req_req[held]) cand = held;
      end else begin
        for (int k = 0; k < NR; k++) begin
          j = (rr + k) % NR;
          if (cand < 0 && req_req[j]) cand = j;
        end
      end
    end
    e_acc  = (cand >= 0) && apu_gnt;
    e_gnt  = e_acc ? NR'(1 << cand) : '0;
    e_resp = apu_rvalid && (q.size() > 0);
    e_rv   = e_resp ? NR'(1 << q[0]) : '0;
    e_ops  = (cand >= 0) ? req_ops[cand] : '0;
    e_op   = (cand >= 0) ? req_op[cand] : '0;
    e_fl   = (cand >= 0) ? req_fl[cand] : '0;
  endtask

  task automatic model_update();
    if (apu_rvalid && q.size() == 0) err_m = 1'b1;
    if (e_resp) void'(q.pop_front());
    if (e_acc) begin
      q.push_back(cand);
      rr = (cand + 1) % NR;
    end
    if (held >= 0) begin
      if (!req_req[held] || apu_gnt) held = -1;
    end else if (cand >= 0 && !apu_gnt) begin
      held = cand;
    end
  endtask

  task automatic check_model();
    chk("m_gnt", 128'(req_gnt), 128'(e_gnt));
    chk("m_rvalid", 128'(req_rvalid), 128'(e_rv));
    chk("m_apu_req", 128'(apu_req), 128'(cand >= 0));
    chk("m_operands", 128'(apu_ops), 128'(e_ops));
    chk("m_op", 128'(apu_op), 128'(e_op));
    chk("m_dflags", 128'(apu_fl), 128'(e_fl));
    chk("m_busy", 128'(busy), 128'(q.size() > 0));
    chk("m_err", 128'(err), 128'(err_m));
    if (e_resp) begin
      chk("m_result", 128'(req_result), 128'(apu_result));
      chk("m_rflags", 128'(req_rflags), 128'(apu_rflags));
    end
  endtask

  // Applies one cycle of inputs after the falling edge and checks the combinational view.
  task automatic drive(input logic [NR-1:0] r, input logic g, input logic v, input logic [31:0] res);
    req_req    = r;
    apu_gnt    = g;
    apu_rvalid = v;
    apu_result = res;
    apu_rflags = APU_NUSFLAGS_CPU'($urandom);
    for (int i = 0; i < NR; i++) begin
      for (int a = 0; a < APU_NARGS_CPU; a++) req_ops[i][a] = $urandom;
      req_op[i] = APU_WOP_CPU'($urandom);
      req_fl[i] = APU_NDSFLAGS_CPU'($urandom);
    end
    #2;
    model_eval();
    check_model();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    req_req    = '0;
    apu_gnt    = 1'b0;
    apu_rvalid = 1'b0;
    apu_result = '0;
    apu_rflags = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  initial begin
    logic [31:0] r;
    logic        v;

    rst_ni     = 1'b0;
    req_req    = '0;
    req_ops    = '0;
    req_op     = '0;
    req_fl     = '0;
    apu_gnt    = 1'b0;
    apu_rvalid = 1'b0;
    apu_result = '0;
    apu_rflags = '0;
    model_reset();
    #2;
    chk("rst_gnt", 128'(req_gnt), 128'(0));
    chk("rst_rvalid", 128'(req_rvalid), 128'(0));
    chk("rst_apu_req", 128'(apu_req), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    do_reset();

    // Single requester round trip, then two requesters alternating from a fresh reset.
    tbl[0] = '{2'b01, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{2'b11, 1'b1, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{2'b11, 1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{2'b11, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{2'b00, 1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst_before) do_reset();
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, 32'hDEAD_BEEF);
      chk($sformatf("tbl%0d_gnt", i), 128'(req_gnt), 128'(tbl[i].x_gnt));
      chk($sformatf("tbl%0d_rvalid", i), 128'(req_rvalid), 128'(tbl[i].x_rv));
      chk($sformatf("tbl%0d_apu_req", i), 128'(apu_req), 128'(tbl[i].x_apu));
      chk($sformatf("tbl%0d_busy", i), 128'(busy), 128'(tbl[i].x_busy));
      if (tbl[i].x_rv != '0) chk($sformatf("tbl%0d_result", i), 128'(req_result), 128'(32'hDEAD_BEEF));
      tick();
    end

    // Stalled grant keeps requester 1 selected although requester 0 has priority.
    do_reset();
    drive(2'b10, 1'b0, 1'b0, '0);
    chk("lock_c0_ops", 128'(apu_ops), 128'(req_ops[1]));
    chk("lock_c0_gnt", 128'(req_gnt), 128'(0));
    tick();
    for (int c = 1; c < 3; c++) begin
      drive(2'b11, 1'b0, 1'b0, '0);
      chk($sformatf("lock_c%0d_ops", c), 128'(apu_ops), 128'(req_ops[1]));
      chk($sformatf("lock_c%0d_gnt", c), 128'(req_gnt), 128'(0));
      chk($sformatf("lock_c%0d_apu_req", c), 128'(apu_req), 128'(1));
      tick();
    end
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("lock_c3_gnt", 128'(req_gnt), 128'(2'b10));
    tick();
    drive(2'b11, 1'b1, 1'b0, '0);
    chk("lock_c4_gnt", 128'(req_gnt), 128'(2'b01));
    tick();

    // Withdrawn request while held: nothing issued, nothing queued.
    do_reset();
    drive(2'b01, 1'b0, 1'b0, '0);
    tick();
    drive(2'b00, 1'b1, 1'b0, '0);
    chk("drop_apu_req", 128'(apu_req), 128'(0));
    chk("drop_gnt", 128'(req_gnt), 128'(0));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("drop_busy", 128'(busy), 128'(0));
    tick();

    // Queue full blocks the fifth request, even in the cycle that pops.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(2'b01, 1'b1, 1'b0, '0);
      chk($sformatf("full_acc%0d", c), 128'(req_gnt), 128'(2'b01));
      tick();
    end
    drive(2'b01, 1'b1, 1'b0, '0);
    chk("full_apu_req", 128'(apu_req), 128'(0));
    chk("full_busy", 128'(busy), 128'(1));
    tick();
    drive(2'b01, 1'b1, 1'b1, 32'h1234_5678);
    chk("full_pop_apu_req", 128'(apu_req), 128'(0));
    chk("full_pop_rvalid", 128'(req_rvalid), 128'(2'b01));
    tick();
    drive(2'b01, 1'b1, 1'b0, '0);
    chk("full_resume_gnt", 128'(req_gnt), 128'(2'b01));
    tick();

    // Spurious response on an empty queue, and in the accept cycle.
    do_reset();
    drive(2'b00, 1'b0, 1'b1, 32'h5555_AAAA);
    chk("spur_rvalid", 128'(req_rvalid), 128'(0));
    chk("spur_err_pre", 128'(err), 128'(0));
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(2'b00, 1'b0, 1'b0, '0);
      chk($sformatf("spur_err_sticky%0d", c), 128'(err), 128'(1));
      tick();
    end
    do_reset();
    drive(2'b01, 1'b1, 1'b1, '0);
    chk("spur_acc_rvalid", 128'(req_rvalid), 128'(0));
    chk("spur_acc_gnt", 128'(req_gnt), 128'(2'b01));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("spur_acc_err", 128'(err), 128'(1));
    chk("spur_acc_busy", 128'(busy), 128'(1));
    tick();

    // Reset with two outstanding, then a late response is spurious.
    do_reset();
    drive(2'b01, 1'b1, 1'b0, '0);
    tick();
    drive(2'b10, 1'b1, 1'b0, '0);
    tick();
    req_req    = 2'b11;
    apu_gnt    = 1'b1;
    apu_rvalid = 1'b1;
    apu_result = 32'hCAFE_F00D;
    rst_ni     = 1'b0;
    #2;
    chk("mrst_gnt", 128'(req_gnt), 128'(0));
    chk("mrst_rvalid", 128'(req_rvalid), 128'(0));
    chk("mrst_apu_req", 128'(apu_req), 128'(0));
    chk("mrst_operands", 128'(apu_ops), 128'(0));
    chk("mrst_result", 128'(req_result), 128'(0));
    chk("mrst_busy", 128'(busy), 128'(0));
    chk("mrst_err", 128'(err), 128'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    drive(2'b00, 1'b0, 1'b1, 32'hCAFE_F00D);
    chk("mrst_late_rvalid", 128'(req_rvalid), 128'(0));
    tick();
    drive(2'b00, 1'b0, 1'b0, '0);
    chk("mrst_late_err", 128'(err), 128'(1));
    tick();

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      r = $urandom;
      if (q.size() > 0) v = ($urandom_range(0, 1) == 1);
      else v = ($urandom_range(0, 40) == 0);
      drive(NR'(r), ($urandom_range(0, 3) != 0), v, $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
